spi_cfg_bank: RTL and testbench

//  Generalised SPI slave for the DSO FPGA: a bank of NUM_REGS REG_W-bit config registers with read-back,

---
 rtl/dso_spi_pkg.sv | 26 ++
 rtl/spi_cfg_bank_if.sv | 12 +
 rtl/spi_sync_edges.sv | 38 +++
 rtl/spi_cfg_bank.sv | 182 ++++++++++++++++++
 tb/tb_spi_cfg_bank.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/dso_spi_pkg.sv
// rtl/dso_spi_pkg.sv - shared command layout, FSM states and helpers for DSO SPI slaves
package dso_spi_pkg;

  localparam int CMD_W         = 8;
  localparam int CMD_WR_BIT    = 7;
  localparam int CMD_BURST_BIT = 6;
  localparam int CMD_ADDR_W    = 6;
  localparam int STATUS_W      = 16;
  localparam logic [CMD_ADDR_W-1:0] MEM_SEL_ADDR = 6'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_REG,
    ST_STAT,
    ST_MEM,
    ST_NULL
  } spi_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_cfg_bank_if.sv
// rtl/spi_cfg_bank_if.sv - SPI pin bundle between MCU master and FPGA slave
interface spi_cfg_bank_if;

  logic ncs_spi;
  logic sck_spi;
  logic mosi_spi;
  logic miso_spi;

  modport master (output ncs_spi, output sck_spi, output mosi_spi, input miso_spi);
  modport slave  (input ncs_spi, input sck_spi, input mosi_spi, output miso_spi);

endinterface

// File: rtl/spi_sync_edges.sv
// rtl/spi_sync_edges.sv - 2-flop synchronisers and edge pulses for async SPI pins
module spi_sync_edges (
  input  logic clk,
  input  logic rst_n,
  input  logic sck_i,
  input  logic ncs_i,
  input  logic mosi_i,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic mosi_o
);

  logic [2:0] sck_q;
  logic [2:0] ncs_q;
  logic [1:0] mosi_q;

  // mosi shares the sck pipeline depth so it is stable when the rise pulse fires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q  <= 3'b000;
      ncs_q  <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sck_q  <= {sck_q[1:0], sck_i};
      ncs_q  <= {ncs_q[1:0], ncs_i};
      mosi_q <= {mosi_q[0], mosi_i};
    end
  end

  assign sck_rise_o = sck_q[1] & ~sck_q[2];
  assign sck_fall_o = ~sck_q[1] & sck_q[2];
  assign start_o    = ~ncs_q[1] & ncs_q[2];
  assign stop_o     = ncs_q[1] & ~ncs_q[2];
  assign mosi_o     = mosi_q[1];

endmodule

// File: rtl/spi_cfg_bank.sv
// rtl/spi_cfg_bank.sv - SPI slave with config register bank, burst access and memory stream
module spi_cfg_bank
  import dso_spi_pkg::*;
#(
  parameter int          NUM_REGS  = 4,
  parameter int          REG_W     = 32,
  parameter int          MEM_W     = 16,
  parameter int          AW        = 12,
  parameter logic [7:0]  DEVICE_ID = 8'h91
) (
  input  logic                      clk,
  input  logic                      rst_n,
  spi_cfg_bank_if.slave             spi,
  output logic [NUM_REGS*REG_W-1:0] cfg_q,
  output logic [NUM_REGS-1:0]       cfg_wr_stb,
  input  logic [15:0]               status_in,
  input  logic [MEM_W-1:0]          mem_data,
  output logic [AW-1:0]             mem_addr
);

  localparam int SH_W  = max3(REG_W, MEM_W, STATUS_W);
  localparam int CNT_W = $clog2(SH_W);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic sck_rise, sck_fall, start, stop, mosi_s;

  spi_sync_edges u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .sck_i      (spi.sck_spi),
    .ncs_i      (spi.ncs_spi),
    .mosi_i     (spi.mosi_spi),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .start_o    (start),
    .stop_o     (stop),
    .mosi_o     (mosi_s)
  );

  spi_state_e                     state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d, last_bit;
  logic [SH_W-2:0]                in_q, in_d;
  logic [SH_W-1:0]                out_q, out_d, word;
  logic                           miso_q, miso_d;
  logic                           wr_q, wr_d, burst_q, burst_d;
  logic [IDX_W-1:0]               idx_q, idx_d, nxt_idx;
  logic [NUM_REGS-1:0][REG_W-1:0] cfg_arr_q, cfg_arr_d;
  logic [NUM_REGS-1:0]            stb_q, stb_d;
  logic [AW-1:0]                  mem_addr_q, mem_addr_d;
  logic                           mem_inc_q, mem_inc_d;
  logic [CMD_ADDR_W-1:0]          cmd_addr;

  assign word     = {in_q, mosi_s};
  assign cmd_addr = word[CMD_ADDR_W-1:0];
  assign nxt_idx  = (idx_q == IDX_W'(NUM_REGS - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    case (state_q)
      ST_REG:  last_bit = CNT_W'(REG_W - 1);
      ST_STAT: last_bit = CNT_W'(STATUS_W - 1);
      ST_MEM:  last_bit = CNT_W'(MEM_W - 1);
      default: last_bit = CNT_W'(CMD_W - 1);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_d       = in_q;
    out_d      = out_q;
    miso_d     = miso_q;
    wr_d       = wr_q;
    burst_d    = burst_q;
    idx_d      = idx_q;
    cfg_arr_d  = cfg_arr_q;
    stb_d      = '0;
    mem_inc_d  = 1'b0;
    mem_addr_d = mem_inc_q ? mem_addr_q + 1'b1 : mem_addr_q;

    if (start) begin
      // first ID bit goes straight to the pin; the shifter holds the rest
      state_d    = ST_CMD;
      cnt_d      = '0;
      in_d       = '0;
      miso_d     = DEVICE_ID[7];
      out_d      = SH_W'(DEVICE_ID[6:0]) << (SH_W - 7);
      mem_addr_d = '0;
    end else if (state_q != ST_IDLE) begin
      if (sck_rise && state_q != ST_NULL) begin
        in_d  = word[SH_W-2:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == last_bit) begin
          cnt_d = '0;
          case (state_q)
            ST_CMD: begin
              wr_d    = word[CMD_WR_BIT];
              burst_d = word[CMD_BURST_BIT];
              if (cmd_addr == MEM_SEL_ADDR) begin
                state_d = ST_STAT;
                out_d   = SH_W'(status_in) << (SH_W - STATUS_W);
              end else if (cmd_addr < CMD_ADDR_W'(NUM_REGS)) begin
                state_d = ST_REG;
                idx_d   = cmd_addr[IDX_W-1:0];
                out_d   = SH_W'(cfg_arr_q[cmd_addr[IDX_W-1:0]]) << (SH_W - REG_W);
              end else begin
                state_d = ST_NULL;
                out_d   = '0;
              end
            end
            ST_REG: begin
              if (wr_q) begin
                cfg_arr_d[idx_q] = word[REG_W-1:0];
                stb_d[idx_q]     = 1'b1;
              end
              // read-back comes from the post-commit bank so a wrapped burst sees fresh data
              if (burst_q) begin
                idx_d = nxt_idx;
                out_d = SH_W'(cfg_arr_d[nxt_idx]) << (SH_W - REG_W);
              end else begin
                state_d = ST_NULL;
                out_d   = '0;
              end
            end
            ST_STAT, ST_MEM: begin
              state_d   = ST_MEM;
              out_d     = SH_W'(mem_data) << (SH_W - MEM_W);
              mem_inc_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      if (sck_fall) begin
        miso_d = (state_q == ST_NULL) ? 1'b0 : out_q[SH_W-1];
        out_d  = out_q << 1;
      end
    end

    // a final edge coinciding with ncs rise still commits above, then the session ends
    if (stop) begin
      state_d = ST_IDLE;
      miso_d  = 1'b0;
    end
    if (state_q == ST_IDLE && !start) miso_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      in_q       <= '0;
      out_q      <= '0;
      miso_q     <= 1'b0;
      wr_q       <= 1'b0;
      burst_q    <= 1'b0;
      idx_q      <= '0;
      cfg_arr_q  <= '0;
      stb_q      <= '0;
      mem_addr_q <= '0;
      mem_inc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_q       <= in_d;
      out_q      <= out_d;
      miso_q     <= miso_d;
      wr_q       <= wr_d;
      burst_q    <= burst_d;
      idx_q      <= idx_d;
      cfg_arr_q  <= cfg_arr_d;
      stb_q      <= stb_d;
      mem_addr_q <= mem_addr_d;
      mem_inc_q  <= mem_inc_d;
    end
  end

  assign cfg_q        = cfg_arr_q;
  assign cfg_wr_stb   = stb_q;
  assign mem_addr     = mem_addr_q;
  assign spi.miso_spi = miso_q;

endmodule

// File: tb/tb_spi_cfg_bank.sv
// tb/tb_spi_cfg_bank.sv - scoreboard bench for spi_cfg_bank
module tb_spi_cfg_bank;

  localparam int NR  = 4;
  localparam int RW  = 32;
  localparam int MW  = 16;
  localparam int TAW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_cfg_bank_if spi ();

  logic [NR*RW-1:0] cfg_q;
  logic [NR-1:0]    cfg_wr_stb;
  logic [15:0]      status_in;
  logic [MW-1:0]    mem_data;
  logic [TAW-1:0]   mem_addr;

  spi_cfg_bank #(
    .NUM_REGS  (NR),
    .REG_W     (RW),
    .MEM_W     (MW),
    .AW        (TAW),
    .DEVICE_ID (8'h91)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi        (spi),
    .cfg_q      (cfg_q),
    .cfg_wr_stb (cfg_wr_stb),
    .status_in  (status_in),
    .mem_data   (mem_data),
    .mem_addr   (mem_addr)
  );

  always @(posedge clk) mem_data <= 16'h0100 + {12'h000, mem_addr};

  typedef struct {
    logic [NR-1:0] mask;
    int            idx;
    logic [RW-1:0] val;
  } stb_t;

  logic [63:0]   exp_miso[$];
  stb_t          exp_stb[$];
  stb_t          mon_s;
  logic [RW-1:0] mdl[NR];
  logic [RW-1:0] wdata[8];
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && cfg_wr_stb != '0) begin
      if (exp_stb.size() == 0) begin
        chk("stb_unexpected", cfg_wr_stb, '0);
      end else begin
        mon_s = exp_stb.pop_front();
        chk("stb_mask", cfg_wr_stb, mon_s.mask);
        chk("stb_value", cfg_q[mon_s.idx*RW +: RW], mon_s.val);
      end
    end
  end

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic xfer(input logic [63:0] tx, input int nbits, input bit do_chk,
                      input bit ncs_last, input string tag);
    logic [63:0] rx;
    logic [63:0] e;
    rx = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi.mosi_spi = tx[i];
      half();
      spi.sck_spi = 1'b1;
      if (ncs_last && i == 0) spi.ncs_spi = 1'b1;
      rx = {rx[62:0], spi.miso_spi};
      half();
      spi.sck_spi = 1'b0;
    end
    if (do_chk) begin
      if (exp_miso.size() == 0) begin
        chk({tag, "_no_expect"}, 64'(exp_miso.size()), 64'd1);
      end else begin
        e = exp_miso.pop_front();
        chk(tag, rx, e);
      end
    end
  endtask

  task automatic sess_begin();
    spi.ncs_spi = 1'b0;
    half();
  endtask

  task automatic sess_end();
    half();
    spi.ncs_spi = 1'b1;
    half();
    half();
  endtask

  task automatic chk_cfg(input string tag);
    chk(tag, cfg_q, {mdl[3], mdl[2], mdl[1], mdl[0]});
  endtask

  // model of register sessions: read-back, commits and burst wrap
  task automatic reg_sess(input logic [7:0] cmd, input int n, input bit ncs_last);
    int a;
    a = int'(cmd[5:0]);
    sess_begin();
    exp_miso.push_back(64'h91);
    xfer(64'(cmd), 8, 1'b1, 1'b0, "cmd_id");
    for (int w = 0; w < n; w++) begin
      if (a < NR) begin
        exp_miso.push_back(64'(mdl[a]));
        if (cmd[7]) begin
          mdl[a] = wdata[w];
          exp_stb.push_back('{mask: NR'(1) << a, idx: a, val: wdata[w]});
        end
        a = cmd[6] ? ((a == NR - 1) ? 0 : a + 1) : 64;
      end else begin
        exp_miso.push_back(64'h0);
      end
      xfer(64'(wdata[w]), RW, 1'b1, ncs_last && (w == n - 1), "reg_word");
    end
    sess_end();
  endtask

  initial begin
    spi.ncs_spi  = 1'b1;
    spi.sck_spi  = 1'b0;
    spi.mosi_spi = 1'b0;
    status_in    = 16'h1234;
    for (int k = 0; k < NR; k++) mdl[k] = '0;
    repeat (4) @(negedge clk);
    chk("rst_cfg", cfg_q, '0);
    chk("rst_stb", cfg_wr_stb, '0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_miso", spi.miso_spi, 1'b0);
    rst_n = 1'b1;
    half();

    wdata[0] = 32'h0;
    reg_sess(8'h00, 1, 1'b0);
    chk_cfg("cfg_after_read");

    wdata[0] = 32'hDEADBEEF;
    reg_sess(8'h81, 1, 1'b0);
    chk_cfg("cfg_after_write1");

    wdata[0] = 32'h11111111; wdata[1] = 32'h22222222; wdata[2] = 32'h33333333;
    reg_sess(8'hC3, 3, 1'b0);
    chk_cfg("cfg_after_burst_wrap");

    wdata[0] = 32'hA0A0A0A0; wdata[1] = 32'hA1A1A1A1; wdata[2] = 32'hA2A2A2A2;
    wdata[3] = 32'hA3A3A3A3; wdata[4] = 32'hA4A4A4A4;
    reg_sess(8'hC0, 5, 1'b0);
    chk_cfg("cfg_after_burst5");

    for (int w = 0; w < 5; w++) wdata[w] = 32'h0;
    reg_sess(8'h42, 5, 1'b0);
    chk_cfg("cfg_after_burst_read");

    sess_begin();
    exp_miso.push_back(64'h91);
    xfer(64'h82, 8, 1'b1, 1'b0, "abort_cmd");
    exp_miso.push_back(64'(mdl[2] >> 12));
    xfer(64'hABCDE, 20, 1'b1, 1'b0, "abort_partial");
    sess_end();
    chk_cfg("cfg_after_abort");

    wdata[0] = 32'h0;
    reg_sess(8'h02, 1, 1'b0);

    sess_begin();
    exp_miso.push_back(64'h91);
    xfer(64'h3F, 8, 1'b1, 1'b0, "stat_cmd");
    exp_miso.push_back(64'h1234);
    xfer(64'h0, 16, 1'b1, 1'b0, "stat_word");
    for (int i = 0; i < 18; i++) begin
      exp_miso.push_back(64'(16'h0100 + 16'(i % 16)));
      xfer(64'hFFFF, 16, 1'b1, 1'b0, "mem_word");
    end
    chk("mem_addr_wrap", mem_addr, TAW'(19 % 16));
    sess_end();

    wdata[0] = 32'hFFFFFFFF; wdata[1] = 32'h12345678;
    reg_sess(8'h90, 2, 1'b0);
    chk_cfg("cfg_after_null");

    wdata[0] = 32'h5A5AA5A5;
    reg_sess(8'h81, 1, 1'b1);
    chk_cfg("cfg_after_ncs_with_last");
    wdata[0] = 32'h0;
    reg_sess(8'h01, 1, 1'b0);

    sess_begin();
    xfer(64'h3F, 8, 1'b0, 1'b0, "");
    xfer(64'h0, 16, 1'b0, 1'b0, "");
    xfer(64'h0, 16, 1'b0, 1'b0, "");
    xfer(64'h0, 7, 1'b0, 1'b0, "");
    rst_n = 1'b0;
    for (int k = 0; k < NR; k++) mdl[k] = '0;
    repeat (2) @(negedge clk);
    chk("midrst_cfg", cfg_q, '0);
    chk("midrst_stb", cfg_wr_stb, '0);
    chk("midrst_mem_addr", mem_addr, '0);
    chk("midrst_miso", spi.miso_spi, 1'b0);
    spi.ncs_spi = 1'b1;
    half();
    rst_n = 1'b1;
    half();

    wdata[0] = 32'hCAFEF00D;
    reg_sess(8'h80, 1, 1'b0);
    chk_cfg("cfg_after_reset_write");

    repeat (4) @(negedge clk);
    chk("miso_queue_drained", 64'(exp_miso.size()), 64'd0);
    chk("stb_queue_drained", 64'(exp_stb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
